// File: rtl/alu_exec_unit_pkg.sv
// Shared constants for the execute-stage ALU: width, operation codes,
// decoder-side ALUOp/funct codes and the sequencing FSM states.
package alu_exec_unit_pkg;

    localparam int DEFAULT_WIDTH = 32;

    localparam logic [3:0] Alu_and = 4'b0000;
    localparam logic [3:0] Alu_or  = 4'b0001;
    localparam logic [3:0] Alu_add = 4'b0010;
    localparam logic [3:0] Alu_xor = 4'b0011;
    localparam logic [3:0] Alu_sub = 4'b0110;
    localparam logic [3:0] Alu_slt = 4'b0111;
    localparam logic [3:0] Alu_mul = 4'b1000;
    localparam logic [3:0] Alu_nor = 4'b1100;

    localparam logic [1:0] Aluop_lw_sw = 2'b00;
    localparam logic [1:0] Aluop_beq   = 2'b01;
    localparam logic [1:0] Aluop_rtype = 2'b10;

    localparam logic [5:0] Add_funct = 6'b100000;
    localparam logic [5:0] Sub_funct = 6'b100010;
    localparam logic [5:0] And_funct = 6'b100100;
    localparam logic [5:0] Or_funct  = 6'b100101;
    localparam logic [5:0] Xor_funct = 6'b100110;
    localparam logic [5:0] Nor_funct = 6'b100111;
    localparam logic [5:0] Slt_funct = 6'b101010;
    localparam logic [5:0] Mul_funct = 6'b011000;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } alu_state_e;

endpackage

// File: rtl/alu_exec_unit_mul_seq.sv
// Iterative shift-add multiplier: one partial-product step per clock,
// WIDTH steps after load; product is the low WIDTH bits.
module alu_mul_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] product,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             active_q, active_d;
    logic [WIDTH-1:0] acc_sum_s;
    logic             done_s;

    // Step datapath; product exposes the accumulator including this edge's add
    always_comb begin
        acc_sum_s  = acc_q + (mplier_q[0] ? mcand_q : {WIDTH{1'b0}});
        done_s     = active_q && (cnt_q == LAST_STEP);
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        active_d   = active_q;
        if (load) begin
            mcand_d  = a;
            mplier_d = b;
            acc_d    = {WIDTH{1'b0}};
            cnt_d    = {CW{1'b0}};
            active_d = 1'b1;
        end else if (active_q) begin
            acc_d    = acc_sum_s;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + {{(CW-1){1'b0}}, 1'b1};
            active_d = !done_s;
        end else begin
            active_d = 1'b0;
        end
    end

    // Multiplier state registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            mcand_q  <= {WIDTH{1'b0}};
            mplier_q <= {WIDTH{1'b0}};
            acc_q    <= {WIDTH{1'b0}};
            cnt_q    <= {CW{1'b0}};
            active_q <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            active_q <= active_d;
        end
    end

    assign product = acc_sum_s;
    assign done    = done_s;

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle logic/arithmetic ops with registered
// result, plus a multi-cycle multiply that holds busy for the hazard unit.
module alu_exec_unit
    import alu_exec_unit_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       Alu_control,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             valid,
    output logic             busy
);

    alu_state_e       state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic [WIDTH-1:0] alu_res_s;
    logic             mul_load_s;
    logic [WIDTH-1:0] mul_product_s;
    logic             mul_done_s;

    alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .reset   (reset),
        .load    (mul_load_s),
        .a       (operand_a),
        .b       (operand_b),
        .product (mul_product_s),
        .done    (mul_done_s)
    );

    // Single-cycle operation select; unlisted codes (and mul here) yield 0
    always_comb begin
        alu_res_s = {WIDTH{1'b0}};
        case (Alu_control)
            Alu_and: alu_res_s = operand_a & operand_b;
            Alu_or:  alu_res_s = operand_a | operand_b;
            Alu_add: alu_res_s = operand_a + operand_b;
            Alu_xor: alu_res_s = operand_a ^ operand_b;
            Alu_sub: alu_res_s = operand_a - operand_b;
            Alu_slt: alu_res_s = {{(WIDTH-1){1'b0}}, ($signed(operand_a) < $signed(operand_b))};
            Alu_nor: alu_res_s = ~(operand_a | operand_b);
            default: alu_res_s = {WIDTH{1'b0}};
        endcase
    end

    // Issue/multiply sequencing; start is ignored outside IDLE
    always_comb begin
        state_d    = state_q;
        result_d   = result_q;
        zero_d     = zero_q;
        valid_d    = 1'b0;
        busy_d     = busy_q;
        mul_load_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && (Alu_control == Alu_mul)) begin
                    mul_load_s = 1'b1;
                    busy_d     = 1'b1;
                    state_d    = ST_MUL;
                end else if (start) begin
                    result_d = alu_res_s;
                    zero_d   = (alu_res_s == {WIDTH{1'b0}});
                    valid_d  = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MUL: begin
                if (mul_done_s) begin
                    result_d = mul_product_s;
                    zero_d   = (mul_product_s == {WIDTH{1'b0}});
                    valid_d  = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = ST_IDLE;
                end else begin
                    state_d = ST_MUL;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Output and state registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            result_q <= {WIDTH{1'b0}};
            zero_q   <= 1'b1;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
        end
    end

    assign result = result_q;
    assign zero   = zero_q;
    assign valid  = valid_q;
    assign busy   = busy_q;

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Execute-stage arithmetic unit that consumes the 4-bit `Alu_control` code produced by the ALU control decoder and performs the selected operation on two 32-bit operands. Single-cycle operations return a registered result one cycle after issue. `mul` runs on an iterative shift-add multiplier and holds `busy` so the hazard unit stalls IF/ID/EX until the product is ready. The block sits between the ID/EX pipeline register and the EX/MEM register.

## Interface
- `WIDTH`, 32, operand and result width.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  active-low, synchronous reset.
- `start`  in  1  issue strobe; sampled on a rising edge only when `busy`=0.
- `Alu_control`  in  4  operation code from the ALU control decoder; sampled with `start`.
- `operand_a`  in  WIDTH  first operand (rs); sampled with `start`.
- `operand_b`  in  WIDTH  second operand (rt or sign-extended immediate); sampled with `start`.
- `result`  out  WIDTH  registered result; holds its value until the next completion.
- `zero`  out  1  registered; equals 1 when `result`=0 (used for branch compare).
- `valid`  out  1  one-cycle pulse marking a new `result`.
- `busy`  out  1  high while a `mul` is in progress; drives the pipeline stall.

## Operation
- Encodings: `Alu_and`=0000, `Alu_or`=0001, `Alu_add`=0010, `Alu_xor`=0011, `Alu_sub`=0110, `Alu_slt`=0111, `Alu_mul`=1000, `Alu_nor`=1100.
- Arithmetic is modulo 2^WIDTH. Carry and overflow are discarded and no exception is raised.
- `slt`: signed compare. Result is 1 if `operand_a` < `operand_b` (two's complement), otherwise 0.
- `mul`: result is the low WIDTH bits of the product. The low bits are identical for signed and unsigned operands.
- Unlisted codes: result 0, `zero`=1, `valid` pulses with single-cycle timing.
- FSM states:
  - IDLE: `start`=1 with a single-cycle op → result loaded, stay in IDLE. `start`=1 with `Alu_mul` → load multiplicand, multiplier, accumulator=0, counter=0, go to MUL.
  - MUL: each edge, if multiplier bit0=1 then accumulator += multiplicand. Then multiplicand <<= 1, multiplier >>= 1, counter += 1. When counter reaches WIDTH-1 on the current edge, load the final accumulator into `result`, pulse `valid`, and go to IDLE.
- `start` while `busy`=1 is ignored. No queuing, no error flag. The hazard unit must hold the instruction.
- Reset (`reset`=0 at an edge), including mid-multiply: state←IDLE, `result`←0, `zero`←1, `valid`←0, `busy`←0, counter and accumulator cleared. The aborted product is never reported.

## Timing
- Reset values: `result`=0, `zero`=1, `valid`=0, `busy`=0.
- Single-cycle op issued at edge k: `result`, `zero` and `valid`=1 are visible after edge k. `valid` returns to 0 after edge k+1 unless another issue occurs at k+1. Back-to-back issues at every edge are supported.
- `mul` issued at edge k: `busy`=1 after edge k. Iterations occur on edges k+1..k+WIDTH. Result, `zero` and `valid`=1 appear after edge k+WIDTH, when `busy` also drops to 0. Latency is WIDTH cycles.
- The earliest next issue after a `mul` is edge k+WIDTH+1.
- `busy` and `valid` are never high in the same cycle.
- `result` and `zero` change only on a `valid` edge or on reset.

## Structure
- The op encodings above, `WIDTH` default and FSM state encodings live in the shared `parameters` module alongside the `Aluop_*` and `*_funct` constants. No literal codes appear in this block.
- One sub-module, `alu_mul_seq`:
  - Contains the iterative shift-add datapath and counter.
  - Ports: `clk`, `reset`, `load`, `a`, `b`, `product`, `done`.
  - Instantiated once; the parent owns the FSM and the output registers.

## Test plan
- Reset held low 3 cycles, then released: `result`=0, `zero`=1, `valid`=0, `busy`=0.
- Back-to-back issues on consecutive edges:
  - add 5+7 → 12, then sub 3−3 → 0 with `zero`=1, then nor 0,0 → 0xFFFFFFFF.
  - Each has `valid` one cycle after its issue.
- slt 0xFFFFFFFF vs 0x00000001 → 1. slt 0x00000001 vs 0xFFFFFFFF → 0. Unused code 1111 → 0 with `valid`.
- mul 0x0000FFFF × 0x00010001 → 0xFFFFFFFF after exactly 32 cycles, `busy` high 32 cycles. A second `start` (add 1+1) pulsed mid-multiply is ignored: no extra `valid`, result stays 0xFFFFFFFF.
- mul 0x80000000 × 2 → 0 with `zero`=1. mul 0xFFFFFFFF × 0xFFFFFFFF → 0x00000001.
- `reset`=0 at cycle 10 of a multiply: outputs go to reset values the next cycle, and no `valid` follows. An add issued afterwards completes normally.
